// File: rtl/program_loader.sv
// program_loader
//   Boot/run sequencer between an external program load stream and the CPU core.
//   After reset it streams program words into instruction memory, optionally
//   seeds the register file with r[k]=k, holds the core in reset for
//   RESET_HOLD_CYCLES cycles, runs it for RUN_CYCLES cycles (0 = forever) and
//   then freezes it with done set.
//
//   Optional feature macro: REG_INIT_EN (adds the register-file seeding phase;
//   when undefined rf_we/rf_addr/rf_wdata are constant 0).
//
// Ports
//   clock        in   system clock, all state on rising edge
//   reset        in   asynchronous active-low reset
//   load_valid   in   load word present
//   load_ready   out  loader accepts a word this cycle
//   load_data    in   program word
//   load_last    in   final word of program
//   imem_we      out  instruction memory write strobe (1 cycle after handshake)
//   imem_addr    out  instruction memory word index
//   imem_wdata   out  instruction memory write data
//   rf_we        out  register file write strobe
//   rf_addr      out  register index
//   rf_wdata     out  register data
//   cpu_reset    out  active-low reset to the core
//   running      out  high while the core executes
//   done         out  sticky, run budget exhausted
//   overflow     out  sticky, program longer than INSTR_MEM_SIZE
//   cycle_count  out  cycles spent in RUN, saturating

module program_loader #(
    parameter int INSTR_MEM_SIZE    = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int RESET_HOLD_CYCLES = 2,
    parameter int RUN_CYCLES        = 5,
    parameter int CNT_W             = 16,
    localparam int ADDR_W = (INSTR_MEM_SIZE > 1) ? $clog2(INSTR_MEM_SIZE) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  rf_we,
    output logic [4:0]            rf_addr,
    output logic [31:0]           rf_wdata,
    output logic                  cpu_reset,
    output logic                  running,
    output logic                  done,
    output logic                  overflow,
    output logic [CNT_W-1:0]      cycle_count
);

    // Word index is one bit wider than the address so "index == depth" is
    // representable; it saturates there instead of wrapping.
    localparam int IDX_W  = $clog2(INSTR_MEM_SIZE + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_RINIT,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state, state_nx;
    logic               armed;
    logic               accept;
    logic [IDX_W-1:0]   idx;
    logic [HOLD_W-1:0]  hcnt;
    logic               hold_end;
    logic               run_end;
    logic               rinit_end;

    // armed keeps load_ready low in the first cycle after reset release.
    assign load_ready = (state == S_LOAD) && armed;
    assign accept     = load_valid && load_ready;
    assign hold_end   = (hcnt == HOLD_W'(RESET_HOLD_CYCLES - 1));
    assign run_end    = (RUN_CYCLES != 0) && (cycle_count == CNT_W'(RUN_CYCLES - 1));

`ifdef REG_INIT_EN
    logic [4:0] rcnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rcnt <= '0;
        end else begin
            rcnt <= (state == S_RINIT) ? rcnt + 5'd1 : '0;
        end
    end

    assign rinit_end = (rcnt == 5'd31);
    assign rf_we     = (state == S_RINIT);
    assign rf_addr   = rcnt;
    assign rf_wdata  = {27'd0, rcnt};
`else
    assign rinit_end = 1'b1;
    assign rf_we     = 1'b0;
    assign rf_addr   = '0;
    assign rf_wdata  = '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cpu_reset = 1'b0;
        running   = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_LOAD: begin
                if (accept && load_last) begin
`ifdef REG_INIT_EN
                    state_nx = S_RINIT;
`else
                    state_nx = S_HOLD;
`endif
                end
            end
            S_RINIT: begin
                if (rinit_end) state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (hold_end) state_nx = S_RUN;
            end
            S_RUN: begin
                cpu_reset = 1'b1;
                running   = 1'b1;
                if (run_end) state_nx = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armed       <= 1'b0;
            idx         <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            overflow    <= 1'b0;
            hcnt        <= '0;
            cycle_count <= '0;
        end else begin
            armed   <= 1'b1;
            imem_we <= 1'b0;
            if (accept) begin
                // Words beyond the memory depth are consumed but dropped.
                if (idx < IDX_W'(INSTR_MEM_SIZE)) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= idx[ADDR_W-1:0];
                    imem_wdata <= load_data;
                    idx        <= idx + IDX_W'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
            hcnt <= (state == S_HOLD) ? hcnt + HOLD_W'(1) : '0;
            if (state == S_RUN && cycle_count != '1) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Scoreboard bench for program_loader. The driver pushes each expected
//   instruction-memory (and register-file) write with the cycle it must appear
//   in; a negedge monitor pops and compares whenever a write strobe is seen.
//   A second instance with RUN_CYCLES=0 shares the load inputs.

module tb_program_loader;

    localparam int SIZE = 32;
    localparam int HOLD = 2;
    localparam int RUNC = 5;
`ifdef REG_INIT_EN
    localparam int RINIT_CYC = 32;
`else
    localparam int RINIT_CYC = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;

    logic        a_load_ready, a_imem_we, a_rf_we, a_cpu_reset, a_running, a_done, a_overflow;
    logic [4:0]  a_imem_addr, a_rf_addr;
    logic [31:0] a_imem_wdata, a_rf_wdata;
    logic [15:0] a_cycle_count;

    logic        z_load_ready, z_imem_we, z_rf_we, z_cpu_reset, z_running, z_done, z_overflow;
    logic [4:0]  z_imem_addr, z_rf_addr;
    logic [31:0] z_imem_wdata, z_rf_wdata;
    logic [15:0] z_cycle_count;

    always #5 clock = ~clock;

    program_loader #(
        .INSTR_MEM_SIZE(SIZE), .DATA_WIDTH(32), .RESET_HOLD_CYCLES(HOLD),
        .RUN_CYCLES(RUNC), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(a_load_ready),
        .load_data(load_data), .load_last(load_last), .imem_we(a_imem_we),
        .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata), .rf_we(a_rf_we),
        .rf_addr(a_rf_addr), .rf_wdata(a_rf_wdata), .cpu_reset(a_cpu_reset),
        .running(a_running), .done(a_done), .overflow(a_overflow),
        .cycle_count(a_cycle_count)
    );

    program_loader #(
        .INSTR_MEM_SIZE(SIZE), .DATA_WIDTH(32), .RESET_HOLD_CYCLES(HOLD),
        .RUN_CYCLES(0), .CNT_W(16)
    ) dut_z (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(z_load_ready),
        .load_data(load_data), .load_last(load_last), .imem_we(z_imem_we),
        .imem_addr(z_imem_addr), .imem_wdata(z_imem_wdata), .rf_we(z_rf_we),
        .rf_addr(z_rf_addr), .rf_wdata(z_rf_wdata), .cpu_reset(z_cpu_reset),
        .running(z_running), .done(z_done), .overflow(z_overflow),
        .cycle_count(z_cycle_count)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t imem_q[$];
    exp_t rf_q[$];
    exp_t mon_e;
    int   ncyc = 0;
    int   vectors = 0;
    int   errors = 0;
    int   idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clock) begin
        ncyc++;
        while (imem_q.size() > 0 && imem_q[0].cyc < ncyc) begin
            vectors++; errors++;
            $display("FAIL imem_missing: no write seen, expected addr %0d in cycle %0d",
                     imem_q[0].addr, imem_q[0].cyc);
            void'(imem_q.pop_front());
        end
        if (a_imem_we === 1'b1) begin
            if (imem_q.size() == 0 || imem_q[0].cyc != ncyc) begin
                vectors++; errors++;
                $display("FAIL imem_spurious: write addr %0d data 0x%0h in cycle %0d, expected none",
                         a_imem_addr, a_imem_wdata, ncyc);
            end else begin
                mon_e = imem_q.pop_front();
                chk("imem_addr", 32'(a_imem_addr), 32'(mon_e.addr));
                chk("imem_wdata", a_imem_wdata, mon_e.data);
            end
        end
        while (rf_q.size() > 0 && rf_q[0].cyc < ncyc) begin
            vectors++; errors++;
            $display("FAIL rf_missing: no write seen, expected r%0d in cycle %0d",
                     rf_q[0].addr, rf_q[0].cyc);
            void'(rf_q.pop_front());
        end
        if (a_rf_we === 1'b1) begin
            if (rf_q.size() == 0 || rf_q[0].cyc != ncyc) begin
                vectors++; errors++;
                $display("FAIL rf_spurious: write r%0d in cycle %0d, expected none", a_rf_addr, ncyc);
            end else begin
                mon_e = rf_q.pop_front();
                chk("rf_addr", 32'(a_rf_addr), 32'(mon_e.addr));
                chk("rf_wdata", a_rf_wdata, mon_e.data);
            end
        end
    end

    // Asserts reset immediately (checks the asynchronous response), then
    // releases it and checks that load_ready rises one edge later.
    task automatic do_reset();
        reset = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        #1;
        chk("rst_load_ready", 32'(a_load_ready), 0);
        chk("rst_cpu_reset", 32'(a_cpu_reset), 0);
        chk("rst_running", 32'(a_running), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_overflow", 32'(a_overflow), 0);
        chk("rst_imem_we", 32'(a_imem_we), 0);
        chk("rst_rf_we", 32'(a_rf_we), 0);
        chk("rst_cycle_count", 32'(a_cycle_count), 0);
        chk("rst_z_state", {z_load_ready, z_cpu_reset, z_running, z_done, z_overflow}, 0);
        chk("rst_z_cycle_count", 32'(z_cycle_count), 0);
        imem_q.delete(); rf_q.delete(); idx = 0;
        @(negedge clock); #1;
        reset = 1'b1;
        chk("ready_before_edge", 32'(a_load_ready), 0);
        @(negedge clock); #1;
        chk("ready_after_release", 32'(a_load_ready), 1);
    endtask

    // Entered and left at falling edge + 1.
    task automatic send(input logic [31:0] d, input logic last);
        int   guard = 0;
        exp_t e;
        load_valid = 1'b1; load_data = d; load_last = last;
        while (a_load_ready !== 1'b1 && guard < 20) begin
            @(negedge clock); #1; guard++;
        end
        if (a_load_ready !== 1'b1) begin
            vectors++; errors++;
            $display("FAIL handshake_timeout: load_ready %b, required 1", a_load_ready);
            load_valid = 1'b0;
            return;
        end
        if (idx < SIZE) begin
            e.cyc = ncyc + 1; e.addr = 5'(idx); e.data = d;
            imem_q.push_back(e);
        end
`ifdef REG_INIT_EN
        if (last) begin
            for (int k = 0; k < 32; k++) begin
                e.cyc = ncyc + 1 + k; e.addr = 5'(k); e.data = 32'(k);
                rf_q.push_back(e);
            end
        end
`endif
        idx++;
        @(negedge clock); #1;
        chk("overflow_flag", 32'(a_overflow), 32'(idx > SIZE));
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0; load_last = 1'b0;
        repeat (n) begin @(negedge clock); #1; end
    endtask

    // Called right after the last word: counts hold and run cycles until done.
    task automatic run_check(input logic exp_ovf);
        int hold = 0, run = 0, bad = 0, guard = 0;
        load_valid = 1'b0; load_last = 1'b0;
        while (a_done !== 1'b1 && guard < 200) begin
            if (a_running === 1'b1) run++; else hold++;
            if (a_cpu_reset !== a_running || a_load_ready !== 1'b0) bad++;
            guard++;
            @(negedge clock); #1;
        end
        if (a_done !== 1'b1) begin
            vectors++; errors++;
            $display("FAIL done_timeout: done %b after %0d cycles, required 1", a_done, guard);
        end
        chk("hold_cycles", hold, HOLD + RINIT_CYC);
        chk("run_cycles", run, RUNC);
        chk("cpu_reset_tracks_run", bad, 0);
        chk("done_running", 32'(a_running), 0);
        chk("done_cpu_reset", 32'(a_cpu_reset), 0);
        chk("done_cycle_count", 32'(a_cycle_count), RUNC);
        chk("done_overflow", 32'(a_overflow), 32'(exp_ovf));
        idle(3);
        chk("done_sticky", {a_done, a_running, a_load_ready}, 3'b100);
        chk("count_frozen", 32'(a_cycle_count), RUNC);
        chk("imem_q_drained", imem_q.size(), 0);
        chk("rf_q_drained", rf_q.size(), 0);
    endtask

    initial begin
        #2;
        // 1: three-word program, valid every cycle
        do_reset();
        send(32'h2008_0005, 1'b0);
        send(32'h2009_0007, 1'b0);
        send(32'h0109_5020, 1'b1);
        run_check(1'b0);

        // 3: valid toggling, 4 words, idle cycles must not write
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(32'hC0DE_0000 + 32'(i), i == 3);
            if (i != 3) idle(1);
        end
        run_check(1'b0);

        // 2: 34-word stream into a 32-word memory
        do_reset();
        for (int i = 0; i < 34; i++) send(32'hA000_0000 + 32'(i), i == 33);
        chk("addr_saturated", 32'(a_imem_addr), SIZE - 1);
        run_check(1'b1);

        // 4: single-word program (register seeding when enabled)
        do_reset();
        send(32'h0000_0013, 1'b1);
        run_check(1'b0);

        // 5: reset during RUN cycle 3, then reload and run
        do_reset();
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b1);
        begin
            int g = 0;
            load_valid = 1'b0; load_last = 1'b0;
            while (a_running !== 1'b1 && g < 100) begin @(negedge clock); #1; g++; end
            chk("run_entered", 32'(a_running), 1);
            repeat (2) begin @(negedge clock); #1; end
            chk("run_cycle3_count", 32'(a_cycle_count), 2);
        end
        do_reset();
        send(32'h3333_3333, 1'b0);
        send(32'h4444_4444, 1'b1);
        run_check(1'b0);

        // 6: RUN_CYCLES=0 instance runs forever
        do_reset();
        send(32'h5555_AAAA, 1'b1);
        chk("z_imem_write", {31'd0, z_imem_we}, 1);
        chk("z_imem_addr", 32'(z_imem_addr), 0);
        chk("z_imem_wdata", z_imem_wdata, 32'h5555_AAAA);
        begin
            int g = 0, bad = 0, k = 0;
            load_valid = 1'b0; load_last = 1'b0;
            while (z_running !== 1'b1 && g < 100) begin
`ifdef REG_INIT_EN
                if (z_rf_we === 1'b1) begin
                    chk("z_rf_addr", 32'(z_rf_addr), k);
                    chk("z_rf_wdata", z_rf_wdata, k);
                    k++;
                end
`endif
                @(negedge clock); #1; g++;
            end
            chk("z_rf_count", k, RINIT_CYC);
            chk("z_run_entered", 32'(z_running), 1);
            for (int i = 0; i < 1000; i++) begin
                @(negedge clock); #1;
                if (z_running !== 1'b1 || z_done !== 1'b0 || z_cpu_reset !== 1'b1 ||
                    z_rf_we !== 1'b0) bad++;
`ifndef REG_INIT_EN
                if (z_rf_addr !== 5'd0 || z_rf_wdata !== 32'd0) bad++;
`endif
            end
            chk("z_forever_bad_cycles", bad, 0);
            chk("z_cycle_count", 32'(z_cycle_count), 1000);
            chk("z_overflow", 32'(z_overflow), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
